// File: rtl/ghost_mode_ctrl.sv
// Global ghost-mode sequencer: arcade scatter/chase schedule with a frightened overlay.
// Drives the scatter/chase/frightened targeting flags and the direction-reverse strobe.
module ghost_mode_ctrl #(
  parameter int CNT_W         = 12,
  parameter int SCATTER_LONG  = 420,
  parameter int SCATTER_SHORT = 300,
  parameter int CHASE_LEN     = 1200,
  parameter int FRIGHT_LEN    = 360,
  parameter int FLASH_LEN     = 120
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       run,
  input  logic       level_start,
  input  logic       energizer,
  output logic       isScatter,
  output logic       isChase,
  output logic       isFrightened,
  output logic       frightFlash,
  output logic       reverse,
  output logic [2:0] phase
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [CNT_W-1:0] L_SL   = CNT_W'(SCATTER_LONG);
  localparam logic [CNT_W-1:0] L_SS   = CNT_W'(SCATTER_SHORT);
  localparam logic [CNT_W-1:0] L_CH   = CNT_W'(CHASE_LEN);
  localparam logic [CNT_W-1:0] L_FR   = CNT_W'(FRIGHT_LEN);
  localparam logic [CNT_W-1:0] L_FL   = CNT_W'(FLASH_LEN);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO   = '0;
  localparam bit               FR_EN  = (FRIGHT_LEN > 0);

  state_t           r_state, w_state;
  logic [2:0]       r_phase, w_phase;
  logic [CNT_W-1:0] r_phase_cnt, w_phase_cnt;
  logic [CNT_W-1:0] r_fright_cnt, w_fright_cnt;
  logic             r_fright, w_fright;
  logic             r_scatter, r_chase, r_flash, r_reverse;
  logic             w_rev_req, w_qual, w_run;

  // Phase 7 is the unbounded final chase, so it carries no length.
  function automatic logic [CNT_W-1:0] phase_len(input logic [2:0] p);
    case (p)
      3'd0, 3'd2:       phase_len = L_SL;
      3'd4, 3'd6:       phase_len = L_SS;
      3'd1, 3'd3, 3'd5: phase_len = L_CH;
      default:          phase_len = ZERO;
    endcase
  endfunction

  always_comb begin
    w_state      = r_state;
    w_phase      = r_phase;
    w_phase_cnt  = r_phase_cnt;
    w_fright_cnt = r_fright_cnt;
    w_fright     = r_fright;
    w_rev_req    = 1'b0;
    w_qual       = tick & run & (r_state == S_RUN);
    if (level_start) begin
      w_state      = S_RUN;
      w_phase      = 3'd0;
      w_phase_cnt  = L_SL;
      w_fright     = 1'b0;
      w_fright_cnt = ZERO;
    end else if ((r_state == S_RUN) && run && energizer) begin
      // Energizer pre-empts any same-cycle tick, so the phase counter stays put.
      w_rev_req = 1'b1;
      if (FR_EN) begin
        w_fright     = 1'b1;
        w_fright_cnt = L_FR;
      end
    end else if (w_qual) begin
      if (r_fright) begin
        if (r_fright_cnt <= ONE) begin
          w_fright     = 1'b0;
          w_fright_cnt = ZERO;
        end else begin
          w_fright_cnt = r_fright_cnt - ONE;
        end
      end else if (r_phase != 3'd7) begin
        if (r_phase_cnt == ONE) begin
          w_phase     = r_phase + 3'd1;
          w_phase_cnt = phase_len(r_phase + 3'd1);
          w_rev_req   = 1'b1;
        end else if (r_phase_cnt > ONE) begin
          w_phase_cnt = r_phase_cnt - ONE;
        end
      end
    end
  end

  assign w_run = (w_state == S_RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_phase      <= 3'd0;
      r_phase_cnt  <= ZERO;
      r_fright_cnt <= ZERO;
      r_fright     <= 1'b0;
      r_scatter    <= 1'b0;
      r_chase      <= 1'b0;
      r_flash      <= 1'b0;
      r_reverse    <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_phase      <= w_phase;
      r_phase_cnt  <= w_phase_cnt;
      r_fright_cnt <= w_fright_cnt;
      r_fright     <= w_fright;
      r_scatter    <= w_run & ~w_fright & ~w_phase[0];
      r_chase      <= w_run & ~w_fright & w_phase[0];
      r_flash      <= w_fright & (w_fright_cnt <= L_FL);
      // Back-to-back requests collapse so the strobe is never two cycles wide.
      r_reverse    <= w_rev_req & ~r_reverse;
    end
  end

  assign isScatter    = r_scatter;
  assign isChase      = r_chase;
  assign isFrightened = r_fright;
  assign frightFlash  = r_flash;
  assign reverse      = r_reverse;
  assign phase        = r_phase;

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// Directed bench for ghost_mode_ctrl using a shortened schedule.
module tb_ghost_mode_ctrl;
  logic       clk = 1'b0;
  logic       reset_n, tick, run, level_start, energizer;
  logic       isScatter, isChase, isFrightened, frightFlash, reverse;
  logic [2:0] phase;
  int         vectors = 0;
  int         fails = 0;
  int         rev_seen;

  ghost_mode_ctrl #(
    .CNT_W(12), .SCATTER_LONG(4), .SCATTER_SHORT(3), .CHASE_LEN(5),
    .FRIGHT_LEN(6), .FLASH_LEN(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .run(run),
    .level_start(level_start), .energizer(energizer),
    .isScatter(isScatter), .isChase(isChase), .isFrightened(isFrightened),
    .frightFlash(frightFlash), .reverse(reverse), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected order: scatter chase frightened flash reverse phase
  task automatic expo(input string tag, input logic sc, input logic ch, input logic fr,
                      input logic fl, input logic rv, input logic [2:0] ph);
    chk(tag, {24'd0, isScatter, isChase, isFrightened, frightFlash, reverse, phase},
        {24'd0, sc, ch, fr, fl, rv, ph});
  endtask

  initial begin
    int lens [7] = '{4, 5, 4, 5, 3, 5, 3};
    logic [2:0] p3, np3;
    reset_n = 1'b0; tick = 1'b0; run = 1'b1; level_start = 1'b0; energizer = 1'b0;
    repeat (2) cyc();
    expo("reset", 0, 0, 0, 0, 0, 3'd0);
    reset_n = 1'b1;
    tick = 1'b1; energizer = 1'b1;
    cyc();
    expo("idle_ignores", 0, 0, 0, 0, 0, 3'd0);
    energizer = 1'b0;

    // Full schedule with a tick every cycle
    level_start = 1'b1;
    cyc();
    expo("level_start", 1, 0, 0, 0, 0, 3'd0);
    level_start = 1'b0;
    rev_seen = 0;
    for (int p = 0; p < 7; p++) begin
      p3 = 3'(p);
      np3 = 3'(p + 1);
      for (int k = 1; k <= lens[p]; k++) begin
        cyc();
        rev_seen += int'(reverse);
        if (k < lens[p]) expo($sformatf("sched_p%0d_t%0d", p, k), ~p3[0], p3[0], 0, 0, 0, p3);
        else             expo($sformatf("advance_p%0d", p + 1), ~np3[0], np3[0], 0, 0, 1, np3);
      end
    end
    for (int k = 0; k < 100; k++) begin
      cyc();
      rev_seen += int'(reverse);
      expo($sformatf("phase7_t%0d", k), 0, 1, 0, 0, 0, 3'd7);
    end
    chk("reverse_total", 32'(rev_seen), 32'd7);

    // Energizer after two ticks of phase 0
    tick = 1'b0; level_start = 1'b1; cyc(); level_start = 1'b0;
    tick = 1'b1; cyc(); cyc();
    expo("pre_energizer", 1, 0, 0, 0, 0, 3'd0);
    tick = 1'b0; energizer = 1'b1; cyc();
    expo("energizer", 0, 0, 1, 0, 1, 3'd0);
    energizer = 1'b0; cyc();
    expo("rev_one_cycle", 0, 0, 1, 0, 0, 3'd0);
    tick = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k < 6) expo($sformatf("fright_t%0d", k), 0, 0, 1, (6 - k) <= 2, 0, 3'd0);
      else       expo("fright_end", 1, 0, 0, 0, 0, 3'd0);
    end
    cyc();
    expo("scatter_resume", 1, 0, 0, 0, 0, 3'd0);
    cyc();
    expo("resume_advance", 0, 1, 0, 0, 1, 3'd1);

    // Second energizer reloads the fright counter
    tick = 1'b0; level_start = 1'b1; cyc(); level_start = 1'b0;
    energizer = 1'b1; cyc();
    expo("en1", 0, 0, 1, 0, 1, 3'd0);
    energizer = 1'b0; tick = 1'b1;
    repeat (4) cyc();
    expo("flash_on", 0, 0, 1, 1, 0, 3'd0);
    tick = 1'b0; energizer = 1'b1; cyc();
    expo("en2_reload", 0, 0, 1, 0, 1, 3'd0);
    energizer = 1'b0; tick = 1'b1;
    repeat (5) cyc();
    expo("reload_last", 0, 0, 1, 1, 0, 3'd0);
    cyc();
    expo("reload_end", 1, 0, 0, 0, 0, 3'd0);

    // Energizer coincident with the expiring tick
    tick = 1'b0; level_start = 1'b1; cyc(); level_start = 1'b0;
    tick = 1'b1; repeat (3) cyc();
    expo("cnt_one", 1, 0, 0, 0, 0, 3'd0);
    energizer = 1'b1; cyc();
    expo("en_vs_expiry", 0, 0, 1, 0, 1, 3'd0);
    energizer = 1'b0;
    repeat (6) cyc();
    expo("held_phase", 1, 0, 0, 0, 0, 3'd0);
    cyc();
    expo("late_advance", 0, 1, 0, 0, 1, 3'd1);

    // run=0 freeze, then level_start while frightened
    tick = 1'b0; level_start = 1'b1; cyc(); level_start = 1'b0;
    tick = 1'b1; cyc(); cyc();
    run = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      expo($sformatf("frozen_%0d", k), 1, 0, 0, 0, 0, 3'd0);
    end
    run = 1'b1; cyc();
    expo("thaw", 1, 0, 0, 0, 0, 3'd0);
    cyc();
    expo("thaw_advance", 0, 1, 0, 0, 1, 3'd1);
    tick = 1'b0; cyc();
    energizer = 1'b1; cyc();
    expo("chase_energizer", 0, 0, 1, 0, 1, 3'd1);
    energizer = 1'b0; cyc();
    level_start = 1'b1; cyc();
    expo("ls_in_fright", 1, 0, 0, 0, 0, 3'd0);
    level_start = 1'b0;

    // Asynchronous reset mid-chase
    tick = 1'b1; repeat (6) cyc();
    expo("mid_chase", 0, 1, 0, 0, 0, 3'd1);
    #2 reset_n = 1'b0;
    #1 expo("async_reset", 0, 0, 0, 0, 0, 3'd0);
    cyc();
    reset_n = 1'b1; energizer = 1'b1;
    repeat (3) cyc();
    expo("post_reset_idle", 0, 0, 0, 0, 0, 3'd0);
    energizer = 1'b0; level_start = 1'b1; cyc();
    expo("restart", 1, 0, 0, 0, 0, 3'd0);
    level_start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
